// File: rtl/ls_down_timer.sv
// Loadable synchronous down-counter/timer with terminal-count flags (BO, DONE) and BUSY.
// Optional feature: define LS_DOWN_TIMER_AUTO_RELOAD_EN to restart from the last load value on expiry.
//
// state   | meaning
// IDLE    | never loaded, or loaded with 0; Q held at 0
// RUN     | counting down toward 0
// EXPIRED | reached 0; holds, or auto-reloads on the next step
module ls_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR_n,
    input  logic [WIDTH-1:0] D,
    input  logic             LOAD_n,
    input  logic             ENP,
    input  logic             ENT,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             DONE,
    output logic             BUSY
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t state;
    logic   step;

`ifdef LS_DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;

    // RELOAD only has an observable effect when auto-reload is built in.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            reload <= '0;
        end else if (!LOAD_n) begin
            reload <= D;
        end
    end
`endif

    assign step = ENP & ENT;
    assign BO   = (Q == '0) & ENT;

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            Q     <= '0;
            state <= IDLE;
            DONE  <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (!LOAD_n) begin
                Q <= D;
                if (D != '0) begin
                    state <= RUN;
                    BUSY  <= 1'b1;
                end else begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        BUSY <= 1'b0;
                    end
                    RUN: begin
                        if (step) begin
                            // Terminal step also covers Q==0 so the counter can never wrap.
                            if (Q > WIDTH'(1)) begin
                                Q    <= Q - WIDTH'(1);
                                BUSY <= 1'b1;
                            end else begin
                                Q     <= '0;
                                state <= EXPIRED;
                                DONE  <= 1'b1;
                                BUSY  <= 1'b0;
                            end
                        end else begin
                            BUSY <= 1'b1;
                        end
                    end
                    EXPIRED: begin
`ifdef LS_DOWN_TIMER_AUTO_RELOAD_EN
                        if (step) begin
                            Q     <= reload;
                            state <= RUN;
                            BUSY  <= 1'b1;
                        end else begin
                            BUSY <= 1'b0;
                        end
`else
                        BUSY <= 1'b0;
`endif
                    end
                    default: begin
                        Q     <= '0;
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ls_down_timer.sv
// Scoreboard bench for ls_down_timer: directed scenarios followed by random stimulus.
module tb_ls_down_timer;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         CLR_n, LOAD_n, ENP, ENT;
    logic [W-1:0] D;
    logic [W-1:0] Q;
    logic         BO, DONE, BUSY;

    ls_down_timer #(.WIDTH(W)) dut (
        .CLK(CLK), .CLR_n(CLR_n), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
        .Q(Q), .BO(BO), .DONE(DONE), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int q;
        bit done;
        bit busy;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference: a count value, the last load value, and whether the timer is counting or has expired.
    int m_q = 0, m_reload = 0;
    bit m_counting = 0, m_expired = 0, m_done = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cycle(input bit clr, input bit ld, input int d, input bit p, input bit t);
        bit auto_en;
        @(negedge CLK);
        CLR_n  = clr;
        LOAD_n = ld;
        D      = W'(d);
        ENP    = p;
        ENT    = t;
`ifdef LS_DOWN_TIMER_AUTO_RELOAD_EN
        auto_en = 1'b1;
`else
        auto_en = 1'b0;
`endif
        m_done = 0;
        if (!clr) begin
            m_q = 0; m_reload = 0; m_counting = 0; m_expired = 0;
        end else if (!ld) begin
            m_q = d % (1 << W);
            m_reload = m_q;
            m_counting = (m_q != 0);
            m_expired = 0;
        end else if (m_counting && p && t) begin
            m_q = m_q - 1;
            if (m_q == 0) begin
                m_counting = 0; m_expired = 1; m_done = 1;
            end
        end else if (m_expired && p && t && auto_en) begin
            m_q = m_reload; m_counting = 1; m_expired = 0;
        end
        sb.push_back('{q: m_q, done: m_done, busy: m_counting});
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("Q", int'(Q), e.q);
                check("DONE", int'(DONE), int'(e.done));
                check("BUSY", int'(BUSY), int'(e.busy));
                check("BO", int'(BO), int'(e.q == 0 && ENT));
            end
        end
    end

    initial begin : driver
        int budget;
        CLR_n = 0; LOAD_n = 1; ENP = 1; ENT = 1; D = '0;
        #1;
        check("reset_Q", int'(Q), 0);
        check("reset_DONE", int'(DONE), 0);
        check("reset_BUSY", int'(BUSY), 0);
        check("reset_BO", int'(BO), 1);
        cycle(0, 1, 0, 1, 1);
        cycle(1, 1, 0, 1, 1);

        // Async clear mid-count with Q=5
        cycle(1, 0, 7, 1, 1);
        cycle(1, 1, 0, 1, 1);
        cycle(1, 1, 0, 1, 1);
        @(posedge CLK);
        #3;
        check("pre_clr_Q", int'(Q), 5);
        CLR_n = 0;
        #1;
        check("async_clr_Q", int'(Q), 0);
        check("async_clr_DONE", int'(DONE), 0);
        check("async_clr_BUSY", int'(BUSY), 0);
        cycle(0, 1, 0, 1, 1);

        // Load 3 and count to expiry, then sit
        cycle(1, 0, 3, 1, 1);
        repeat (5) cycle(1, 1, 0, 1, 1);

        // Hold with ENP=0, then ENT=0
        cycle(1, 0, 6, 1, 1);
        repeat (4) cycle(1, 1, 0, 0, 1);
        repeat (3) cycle(1, 1, 0, 1, 0);

        // Load beats count
        cycle(1, 0, 4, 1, 1);
        cycle(1, 0, 9, 1, 1);
        cycle(1, 1, 0, 1, 1);

        // Load zero: idle, BO follows ENT
        cycle(1, 0, 0, 1, 1);
        repeat (3) cycle(1, 1, 0, 1, 1);
        repeat (2) cycle(1, 1, 0, 1, 0);

        // Load 2 with enables high for nine cycles
        cycle(1, 0, 2, 1, 1);
        repeat (9) cycle(1, 1, 0, 1, 1);
        cycle(1, 0, 1, 1, 1);
        repeat (3) cycle(1, 1, 0, 1, 1);

        // Random phase
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 63) != 0),
                  ($urandom_range(0, 9) != 0),
                  $urandom_range(0, (1 << W) - 1),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0));
        end

        budget = 20;
        while (sb.size() > 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
